seg7_scan_decoder: RTL

Receive-side counterpart of the hex-to-seven-segment encoder. Monitors a multiplexed, active-low seven-segment display bus (digit enables plus shared segment lines), waits for each scanned pattern to be stable, decodes it back to a hex nibble, and assembles the full displayed word. Used on-chip and in benches to read back what the display path is showing. Flags any lit pattern that is not one of the 16 encoder glyphs.

---
 rtl/seg7_scan_decoder_if.sv | 24 ++
 rtl/seg7_scan_decoder.sv | 136 +++++++++++++
 2 files changed

// File: rtl/seg7_scan_decoder_if.sv
// Display-bus readback interface: scanned an/seg plus clear in,
// decoded word and status out. master = bus driver, slave = decoder.
interface seg7_scan_decoder_if #(
  parameter int NDIGITS = 4
) ();
  logic [NDIGITS-1:0]   an;
  logic [6:0]           seg;
  logic                 clear;
  logic [4*NDIGITS-1:0] value;
  logic [NDIGITS-1:0]   digit_valid;
  logic                 frame_valid;
  logic                 err;
  logic [2:0]           err_digit;

  modport master (
    output an, seg, clear,
    input  value, digit_valid, frame_valid, err, err_digit
  );

  modport slave (
    input  an, seg, clear,
    output value, digit_valid, frame_valid, err, err_digit
  );
endinterface

// File: rtl/seg7_scan_decoder.sv
// Seven-segment scan decoder: debounces each scanned digit and decodes it.
// Ports: clk, rst_n (async low), bus (slave: an/seg/clear in, value/status out).
module seg7_scan_decoder #(
  parameter int NDIGITS       = 4,
  parameter int STABLE_CYCLES = 4
) (
  input  logic               clk,
  input  logic               rst_n,
  seg7_scan_decoder_if.slave bus
);
  localparam int         VW  = 4 * NDIGITS;
  localparam logic [7:0] SAT = 8'(STABLE_CYCLES + 1);
  localparam logic [7:0] ACC = 8'(STABLE_CYCLES);

  logic [NDIGITS-1:0] an_q, an_p;
  logic [6:0]         seg_q, seg_p;
  logic [7:0]         cnt, cnt_nxt;
  logic [VW-1:0]      value_q, value_nxt;
  logic [NDIGITS-1:0] dv_q, dv_nxt;
  logic               fv_q, fv_nxt;
  logic               err_q, err_nxt;
  logic [2:0]         ed_q, ed_nxt;
  logic [3:0]         nzero;
  logic               legal, same, accept;
  logic               hit, blank;
  logic [3:0]         nib;

  always_comb begin
    nzero = '0;
    for (int i = 0; i < NDIGITS; i++) begin
      if (!an_q[i]) nzero = nzero + 4'd1;
    end
    legal = (nzero == 4'd1);
  end

  // The previous sample is a full (an, seg) pair, so a digit
  // switch with an identical segment pattern still restarts the run.
  assign same   = (an_q == an_p) && (seg_q == seg_p);
  assign accept = legal && same && (cnt == ACC - 8'd1);

  always_comb begin
    if (!legal)           cnt_nxt = 8'd0;
    else if (!same)       cnt_nxt = 8'd1;
    else if (cnt >= SAT)  cnt_nxt = SAT;
    else                  cnt_nxt = cnt + 8'd1;
  end

  always_comb begin
    hit = 1'b1;
    nib = 4'h0;
    case (seg_q)
      7'b1000000: nib = 4'h0;
      7'b1111001: nib = 4'h1;
      7'b0100100: nib = 4'h2;
      7'b0110000: nib = 4'h3;
      7'b0011001: nib = 4'h4;
      7'b0010010: nib = 4'h5;
      7'b0000010: nib = 4'h6;
      7'b1111000: nib = 4'h7;
      7'b0000000: nib = 4'h8;
      7'b0011000: nib = 4'h9;
      7'b0001000: nib = 4'hA;
      7'b0000011: nib = 4'hB;
      7'b1000110: nib = 4'hC;
      7'b0100001: nib = 4'hD;
      7'b0000110: nib = 4'hE;
      7'b0001110: nib = 4'hF;
      default:    hit = 1'b0;
    endcase
    blank = (seg_q == 7'h7F);
  end

  // an_q is one-hot-low whenever accept is set, so at most one
  // digit slot below is touched per cycle.
  always_comb begin
    value_nxt = value_q;
    dv_nxt    = dv_q;
    err_nxt   = err_q;
    ed_nxt    = ed_q;
    for (int i = 0; i < NDIGITS; i++) begin
      if (accept && !an_q[i]) begin
        if (hit) begin
          value_nxt[4*i +: 4] = nib;
          dv_nxt[i]           = 1'b1;
        end else if (blank) begin
          dv_nxt[i] = 1'b0;
        end else begin
          err_nxt = 1'b1;
          ed_nxt  = 3'(i);
        end
      end
    end
    fv_nxt = accept && !an_q[NDIGITS-1] && (&dv_nxt);
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      an_q    <= '1;
      seg_q   <= 7'h7F;
      an_p    <= '1;
      seg_p   <= 7'h7F;
      cnt     <= 8'd0;
      value_q <= '0;
      dv_q    <= '0;
      fv_q    <= 1'b0;
      err_q   <= 1'b0;
      ed_q    <= 3'd0;
    end else begin
      an_q  <= bus.an;
      seg_q <= bus.seg;
      an_p  <= an_q;
      seg_p <= seg_q;
      if (bus.clear) begin
        cnt     <= 8'd0;
        value_q <= '0;
        dv_q    <= '0;
        fv_q    <= 1'b0;
        err_q   <= 1'b0;
        ed_q    <= 3'd0;
      end else begin
        cnt     <= cnt_nxt;
        value_q <= value_nxt;
        dv_q    <= dv_nxt;
        fv_q    <= fv_nxt;
        err_q   <= err_nxt;
        ed_q    <= ed_nxt;
      end
    end
  end

  assign bus.value       = value_q;
  assign bus.digit_valid = dv_q;
  assign bus.frame_valid = fv_q;
  assign bus.err         = err_q;
  assign bus.err_digit   = ed_q;
endmodule
